accum_int64_feed: RTL and testbench

Operand sequencer on the issue side of the explicit 108-term integer accumulate unit. It collects a stream of 64-bit terms for one accumulate instruction into a zero-padded 108-slot buffer. It issues the whole buffer to the accumulator with a single `din_en` pulse, then follows the accumulator's `res_en`/`res` return protocol. The 65-bit result is handed back to the pipeline, tagged, with a ready/valid handshake.

---
 rtl/accum_int64_feed.sv | 165 ++++++++++++++++
 tb/tb_accum_int64_feed.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accum_int64_feed.sv
// Collects one instruction's 64-bit terms into a zero-padded TERMS-slot buffer, issues it with one
// din_en pulse, and returns the tagged accumulator result over valid/ready. One group in flight.
module accum_int64_feed #(
  parameter int TERMS = 108,
  parameter int TAGW  = 4,
  parameter int TMO   = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_vld,
  input  logic [63:0]            in_term,
  input  logic                   in_last,
  input  logic [TAGW-1:0]        in_tag,
  output logic                   in_rdy,
  output logic [63:0]            acc_A,
  output logic [TERMS-1:0][63:0] acc_B,
  output logic                   acc_din_en,
  input  logic                   acc_res_en,
  input  logic [64:0]            acc_res,
  output logic                   out_vld,
  output logic [64:0]            out_sum,
  output logic [TAGW-1:0]        out_tag,
  output logic [7:0]             out_cnt,
  output logic                   out_ovf,
  output logic                   out_err,
  input  logic                   out_rdy
);

  localparam int IDXW = (TERMS > 1) ? $clog2(TERMS) : 1;
  localparam int WDW  = $clog2(TMO) + 1;

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_ISSUE, S_WAIT, S_CAPT, S_HOLD} state_t;

  state_t                 state_q, state_d;
  logic                   live_q;
  logic [TERMS-1:0][63:0] buf_q, buf_d;
  logic [7:0]             cnt_q, cnt_d;
  logic [TAGW-1:0]        tag_q, tag_d;
  logic                   ovf_q, ovf_d;
  logic [WDW-1:0]         wd_q, wd_d;
  logic [64:0]            osum_q, osum_d;
  logic [TAGW-1:0]        otag_q, otag_d;
  logic [7:0]             ocnt_q, ocnt_d;
  logic                   oovf_q, oovf_d;
  logic                   oerr_q, oerr_d;
  logic                   accept;

  // live_q keeps in_rdy low for the first cycle after any reset edge
  assign in_rdy     = live_q && (state_q == S_IDLE || state_q == S_FILL);
  assign acc_din_en = (state_q == S_ISSUE);
  assign out_vld    = (state_q == S_HOLD);
  assign accept     = in_vld && in_rdy;

  assign acc_A   = '0;
  assign acc_B   = buf_q;
  assign out_sum = osum_q;
  assign out_tag = otag_q;
  assign out_cnt = ocnt_q;
  assign out_ovf = oovf_q;
  assign out_err = oerr_q;

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    tag_d   = tag_q;
    ovf_d   = ovf_q;
    wd_d    = wd_q;
    osum_d  = osum_q;
    otag_d  = otag_q;
    ocnt_d  = ocnt_q;
    oovf_d  = oovf_q;
    oerr_d  = oerr_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          buf_d[0] = in_term;
          tag_d    = in_tag;
          cnt_d    = 8'd1;
          ovf_d    = !in_last && (TERMS == 1);
          state_d  = (in_last || TERMS == 1) ? S_ISSUE : S_FILL;
        end
      end
      S_FILL: begin
        if (accept) begin
          buf_d[cnt_q[IDXW-1:0]] = in_term;
          cnt_d = cnt_q + 8'd1;
          if (in_last) begin
            state_d = S_ISSUE;
          end else if (cnt_q == 8'(TERMS - 1)) begin
            ovf_d   = 1'b1;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Timeout fires on the edge where the count would reach TMO-1; a strobe wins the tie.
        if (acc_res_en) begin
          state_d = S_CAPT;
        end else if (wd_q == WDW'(TMO - 2)) begin
          osum_d  = '0;
          oerr_d  = 1'b1;
          otag_d  = tag_q;
          ocnt_d  = cnt_q;
          oovf_d  = ovf_q;
          state_d = S_HOLD;
        end else begin
          wd_d = wd_q + WDW'(1);
        end
      end
      S_CAPT: begin
        osum_d  = acc_res;
        oerr_d  = 1'b0;
        otag_d  = tag_q;
        ocnt_d  = cnt_q;
        oovf_d  = ovf_q;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (out_rdy) begin
          buf_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      live_q  <= 1'b0;
      buf_q   <= '0;
      cnt_q   <= '0;
      tag_q   <= '0;
      ovf_q   <= 1'b0;
      wd_q    <= '0;
      osum_q  <= '0;
      otag_q  <= '0;
      ocnt_q  <= '0;
      oovf_q  <= 1'b0;
      oerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      tag_q   <= tag_d;
      ovf_q   <= ovf_d;
      wd_q    <= wd_d;
      osum_q  <= osum_d;
      otag_q  <= otag_d;
      ocnt_q  <= ocnt_d;
      oovf_q  <= oovf_d;
      oerr_q  <= oerr_d;
    end
  end

endmodule

// File: tb/tb_accum_int64_feed.sv
// Directed bench for accum_int64_feed: drives terms and a hand-scripted accumulator response.
module tb_accum_int64_feed;

  logic               clk;
  logic               rst;
  logic               in_vld;
  logic [63:0]        in_term;
  logic               in_last;
  logic [3:0]         in_tag;
  logic               in_rdy;
  logic [63:0]        acc_A;
  logic [107:0][63:0] acc_B;
  logic               acc_din_en;
  logic               acc_res_en;
  logic [64:0]        acc_res;
  logic               out_vld;
  logic [64:0]        out_sum;
  logic [3:0]         out_tag;
  logic [7:0]         out_cnt;
  logic               out_ovf;
  logic               out_err;
  logic               out_rdy;

  int checks = 0;
  int errors = 0;

  accum_int64_feed #(.TERMS(108), .TAGW(4), .TMO(32)) dut (
    .clk(clk), .rst(rst),
    .in_vld(in_vld), .in_term(in_term), .in_last(in_last), .in_tag(in_tag), .in_rdy(in_rdy),
    .acc_A(acc_A), .acc_B(acc_B), .acc_din_en(acc_din_en),
    .acc_res_en(acc_res_en), .acc_res(acc_res),
    .out_vld(out_vld), .out_sum(out_sum), .out_tag(out_tag), .out_cnt(out_cnt),
    .out_ovf(out_ovf), .out_err(out_err), .out_rdy(out_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] t, input logic last, input logic [3:0] tag);
    int n = 0;
    in_vld  = 1'b1;
    in_term = t;
    in_last = last;
    in_tag  = tag;
    while (!in_rdy && n < 200) begin
      tick();
      n++;
    end
    tick();
    in_vld  = 1'b0;
    in_last = 1'b0;
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: in_rdy stayed %0b, expected 1", in_rdy);
    end
  endtask

  task automatic reply(input logic [64:0] res, input int dly);
    for (int i = 0; i < dly; i++) tick();
    acc_res_en = 1'b1;
    tick();
    acc_res_en = 1'b0;
    acc_res    = res;
    tick();
    acc_res    = 65'h0_DEAD_BEEF;
  endtask

  task automatic consume();
    out_rdy = 1'b1;
    tick();
    out_rdy = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    checks++; if (in_rdy !== 1'b0) begin errors++; $display("FAIL rst_in_rdy got=%0b exp=0", in_rdy); end
    checks++; if (acc_din_en !== 1'b0) begin errors++; $display("FAIL rst_din_en got=%0b exp=0", acc_din_en); end
    checks++; if (acc_A !== 64'd0) begin errors++; $display("FAIL rst_acc_A got=%0h exp=0", acc_A); end
    checks++; if (acc_B !== '0) begin errors++; $display("FAIL rst_acc_B got=nonzero exp=0"); end
    checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL rst_out_vld got=%0b exp=0", out_vld); end
    checks++; if ({out_sum, out_tag, out_cnt, out_ovf, out_err} !== '0) begin
      errors++; $display("FAIL rst_outs sum=%0h tag=%0h cnt=%0d ovf=%0b err=%0b exp all 0",
                         out_sum, out_tag, out_cnt, out_ovf, out_err);
    end
    rst = 1'b1;
    tick();
    checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL rst_in_rdy_after got=%0b exp=1", in_rdy); end
  endtask

  task automatic test_single();
    logic [107:0][63:0] exp_b;
    exp_b = '0;
    exp_b[0] = 64'd5;
    push(64'd5, 1'b1, 4'd3);
    checks++; if (acc_din_en !== 1'b1) begin errors++; $display("FAIL single_din_en got=%0b exp=1", acc_din_en); end
    checks++; if (acc_B !== exp_b) begin errors++; $display("FAIL single_acc_B slot0=%0h exp=5 (or other slot nonzero)", acc_B[0]); end
    tick();
    checks++; if (acc_din_en !== 1'b0) begin errors++; $display("FAIL single_din_pulse got=%0b exp=0", acc_din_en); end
    reply(65'd5, 3);
    checks++; if (out_vld !== 1'b1) begin errors++; $display("FAIL single_out_vld got=%0b exp=1", out_vld); end
    checks++; if (out_sum !== 65'd5) begin errors++; $display("FAIL single_sum got=%0h exp=5", out_sum); end
    checks++; if (out_tag !== 4'd3) begin errors++; $display("FAIL single_tag got=%0h exp=3", out_tag); end
    checks++; if (out_cnt !== 8'd1) begin errors++; $display("FAIL single_cnt got=%0d exp=1", out_cnt); end
    checks++; if (out_ovf !== 1'b0 || out_err !== 1'b0) begin
      errors++; $display("FAIL single_flags ovf=%0b err=%0b exp 0/0", out_ovf, out_err);
    end
    consume();
    checks++; if (in_rdy !== 1'b1 || out_vld !== 1'b0) begin
      errors++; $display("FAIL single_turnaround in_rdy=%0b out_vld=%0b exp 1/0", in_rdy, out_vld);
    end
  endtask

  task automatic test_gaps();
    logic [107:0][63:0] exp_b;
    exp_b = '0;
    exp_b[0] = 64'd1;
    exp_b[1] = 64'd2;
    exp_b[2] = 64'hFFFF_FFFF_FFFF_FFFF;
    push(64'd1, 1'b0, 4'd9);
    tick();
    tick();
    push(64'd2, 1'b0, 4'd0);
    tick();
    push(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 4'd0);
    checks++; if (acc_din_en !== 1'b1) begin errors++; $display("FAIL gaps_din_en got=%0b exp=1", acc_din_en); end
    checks++; if (acc_B !== exp_b) begin
      errors++; $display("FAIL gaps_acc_B got=%0h,%0h,%0h exp=1,2,ffffffffffffffff", acc_B[0], acc_B[1], acc_B[2]);
    end
    reply(65'h1_0000_0000_0000_0002, 2);
    checks++; if (out_sum !== 65'h1_0000_0000_0000_0002) begin
      errors++; $display("FAIL gaps_sum got=%0h exp=10000000000000002", out_sum);
    end
    checks++; if (out_cnt !== 8'd3) begin errors++; $display("FAIL gaps_cnt got=%0d exp=3", out_cnt); end
    checks++; if (out_tag !== 4'd9) begin errors++; $display("FAIL gaps_tag got=%0h exp=9", out_tag); end
    consume();
  endtask

  task automatic test_full();
    logic [107:0][63:0] exp_b;
    int early = 0;
    for (int i = 0; i < 108; i++) begin
      exp_b[i] = 64'hFFFF_FFFF_FFFF_FFFF;
      push(64'hFFFF_FFFF_FFFF_FFFF, (i == 107), 4'hA);
      if (i < 107 && acc_din_en !== 1'b0) early++;
    end
    checks++; if (early !== 0) begin errors++; $display("FAIL full_early_issue got=%0d exp=0", early); end
    checks++; if (acc_din_en !== 1'b1) begin errors++; $display("FAIL full_din_en got=%0b exp=1", acc_din_en); end
    checks++; if (acc_B !== exp_b) begin errors++; $display("FAIL full_acc_B slot107=%0h exp=all ones", acc_B[107]); end
    reply(65'h1_FFFF_FFFF_FFFF_FF94, 4);
    checks++; if (out_sum !== 65'h1_FFFF_FFFF_FFFF_FF94) begin
      errors++; $display("FAIL full_sum got=%0h exp=1ffffffffffffff94", out_sum);
    end
    checks++; if (out_cnt !== 8'd108 || out_ovf !== 1'b0) begin
      errors++; $display("FAIL full_cnt_ovf cnt=%0d ovf=%0b exp 108/0", out_cnt, out_ovf);
    end
    consume();
  endtask

  task automatic test_overflow();
    logic [107:0][63:0] exp_b;
    int rdy_bad = 0;
    for (int i = 0; i < 108; i++) begin
      exp_b[i] = 64'hFFFF_FFFF_FFFF_FFFF;
      push(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 4'hB);
    end
    checks++; if (acc_din_en !== 1'b1) begin errors++; $display("FAIL ovf_close got=%0b exp=1", acc_din_en); end
    in_vld  = 1'b1;
    in_term = 64'h77;
    for (int i = 0; i < 3; i++) begin
      if (in_rdy !== 1'b0) rdy_bad++;
      tick();
    end
    reply(65'h1_FFFF_FFFF_FFFF_FF94, 1);
    if (in_rdy !== 1'b0) rdy_bad++;
    checks++; if (rdy_bad !== 0) begin errors++; $display("FAIL ovf_in_rdy high_cycles=%0d exp=0", rdy_bad); end
    checks++; if (acc_B !== exp_b) begin errors++; $display("FAIL ovf_acc_B slot0=%0h exp=all ones", acc_B[0]); end
    checks++; if (out_ovf !== 1'b1 || out_cnt !== 8'd108) begin
      errors++; $display("FAIL ovf_flags ovf=%0b cnt=%0d exp 1/108", out_ovf, out_cnt);
    end
    in_vld = 1'b0;
    consume();
  endtask

  task automatic test_backpressure();
    int bad = 0;
    push(64'd7, 1'b0, 4'd5);
    push(64'd8, 1'b1, 4'd5);
    reply(65'd15, 1);
    for (int i = 0; i < 10; i++) begin
      acc_res_en = (i == 3);
      acc_res    = (i == 4) ? 65'd99 : 65'h0_DEAD_BEEF;
      if (out_vld !== 1'b1 || in_rdy !== 1'b0 || out_sum !== 65'd15 || out_tag !== 4'd5 ||
          out_cnt !== 8'd2 || out_ovf !== 1'b0 || out_err !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold cyc=%0d vld=%0b rdy=%0b sum=%0h tag=%0h cnt=%0d exp 1/0/f/5/2",
                 i, out_vld, in_rdy, out_sum, out_tag, out_cnt);
      end
      tick();
    end
    acc_res_en = 1'b0;
    checks++; errors += bad;
    consume();
    checks++; if (in_rdy !== 1'b1 || out_vld !== 1'b0 || acc_din_en !== 1'b0) begin
      errors++; $display("FAIL bp_release rdy=%0b vld=%0b din=%0b exp 1/0/0", in_rdy, out_vld, acc_din_en);
    end
    checks++; if (acc_B !== '0) begin errors++; $display("FAIL bp_clear slot0=%0h slot1=%0h exp 0", acc_B[0], acc_B[1]); end
    checks++; if (out_sum !== 65'd15) begin errors++; $display("FAIL bp_sum_hold got=%0h exp=f", out_sum); end
  endtask

  task automatic test_watchdog();
    int early = 0;
    push(64'd3, 1'b1, 4'd2);
    for (int i = 1; i < 32; i++) begin
      tick();
      if (out_vld !== 1'b0) early++;
    end
    checks++; if (early !== 0) begin errors++; $display("FAIL wd_early got=%0d exp=0", early); end
    tick();
    checks++; if (out_vld !== 1'b1 || out_err !== 1'b1) begin
      errors++; $display("FAIL wd_fire vld=%0b err=%0b exp 1/1", out_vld, out_err);
    end
    checks++; if (out_sum !== 65'd0 || out_tag !== 4'd2 || out_cnt !== 8'd1) begin
      errors++; $display("FAIL wd_outs sum=%0h tag=%0h cnt=%0d exp 0/2/1", out_sum, out_tag, out_cnt);
    end
    consume();
  endtask

  task automatic test_reset_mid();
    push(64'd4, 1'b1, 4'd6);
    tick();
    tick();
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checks++; if (out_vld !== 1'b0 || in_rdy !== 1'b0 || acc_din_en !== 1'b0 || acc_B !== '0) begin
      errors++; $display("FAIL mid_rst_ctl vld=%0b rdy=%0b din=%0b exp 0/0/0, buffer 0", out_vld, in_rdy, acc_din_en);
    end
    checks++; if ({out_sum, out_tag, out_cnt, out_ovf, out_err} !== '0) begin
      errors++; $display("FAIL mid_rst_outs sum=%0h tag=%0h cnt=%0d exp 0", out_sum, out_tag, out_cnt);
    end
    acc_res_en = 1'b1;
    tick();
    acc_res_en = 1'b0;
    acc_res    = 65'd4;
    tick();
    tick();
    checks++; if (out_vld !== 1'b0 || in_rdy !== 1'b1 || out_sum !== 65'd0) begin
      errors++; $display("FAIL mid_drop vld=%0b rdy=%0b sum=%0h exp 0/1/0", out_vld, in_rdy, out_sum);
    end
    push(64'd10, 1'b0, 4'd1);
    push(64'd20, 1'b1, 4'd1);
    checks++; if (acc_din_en !== 1'b1) begin errors++; $display("FAIL mid_next_din got=%0b exp=1", acc_din_en); end
    reply(65'd30, 2);
    checks++; if (out_vld !== 1'b1 || out_sum !== 65'd30 || out_cnt !== 8'd2 || out_tag !== 4'd1) begin
      errors++; $display("FAIL mid_next vld=%0b sum=%0h cnt=%0d tag=%0h exp 1/1e/2/1", out_vld, out_sum, out_cnt, out_tag);
    end
    consume();
  endtask

  initial begin
    rst        = 1'b0;
    in_vld     = 1'b0;
    in_term    = '0;
    in_last    = 1'b0;
    in_tag     = '0;
    acc_res_en = 1'b0;
    acc_res    = '0;
    out_rdy    = 1'b0;
    test_reset();
    test_single();
    test_gaps();
    test_full();
    test_overflow();
    test_backpressure();
    test_watchdog();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
